cache_miss_ctrl: RTL and testbench

Sequencing controller for the data cache miss path. It looks up each CPU access in the tag array and reports hits. On a miss it runs the write-back unit (dirty victims only), then the refill unit, then rewrites the tag entry. The CPU pipeline is held stalled until the re-issued lookup hits. It sits between the pipeline memory stage, the tag array, and the two line-transfer units, and owns their start/done handshakes.

---
 rtl/cache_miss_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// Data-cache miss sequencer: tag lookup, optional victim write-back, line refill,
// tag rewrite, then re-lookup of the held CPU access.
module cache_miss_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  output logic        stall,
  output logic [5:0]  tag_index,
  input  logic [20:0] tag_rd_tag,
  input  logic        tag_rd_valid,
  input  logic        tag_rd_dirty,
  output logic        tag_we,
  output logic [20:0] tag_wr_tag,
  output logic        tag_wr_valid,
  output logic        tag_wr_dirty,
  output logic        wb_start,
  output logic [31:0] wb_addr,
  input  logic        wb_done,
  output logic        rf_start,
  output logic [31:0] rf_addr,
  input  logic        rf_done,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [2:0]  dbg_state
);

  // Encoding order is also the dbg_state encoding: 0..4.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_WB_WAIT = 3'd2,
    S_RF_WAIT = 3'd3,
    S_UPDATE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [26:0] r_line;
  logic        r_we;
  logic        r_wb_start;
  logic        r_rf_start;
  logic [31:0] r_wb_addr;
  logic [31:0] r_rf_addr;
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  logic [20:0] w_tag;
  logic [5:0]  w_index;
  logic        w_hit;
  logic        w_victim_dirty;
  logic        w_unused;

  assign w_tag          = r_line[26:6];
  assign w_index        = r_line[5:0];
  assign w_hit          = tag_rd_valid && (tag_rd_tag == w_tag);
  // Only a valid line can be dirty in any meaningful sense.
  assign w_victim_dirty = tag_rd_valid && tag_rd_dirty;
  assign w_unused       = ^req_addr[4:0];

  always_comb begin
    w_next       = r_state;
    stall        = 1'b0;
    tag_we       = 1'b0;
    tag_wr_tag   = w_tag;
    tag_wr_valid = 1'b1;
    tag_wr_dirty = 1'b0;
    tag_index    = w_index;
    case (r_state)
      S_IDLE: begin
        tag_index = req_addr[10:5];
        stall     = req;
        if (req) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        stall = !w_hit;
        if (w_hit) begin
          w_next = S_IDLE;
          if (r_we && !tag_rd_dirty) begin
            tag_we       = 1'b1;
            tag_wr_dirty = 1'b1;
          end
        end else begin
          w_next = w_victim_dirty ? S_WB_WAIT : S_RF_WAIT;
        end
      end
      S_WB_WAIT: begin
        stall = 1'b1;
        if (wb_done) w_next = S_RF_WAIT;
      end
      S_RF_WAIT: begin
        stall = 1'b1;
        if (rf_done) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        stall  = 1'b1;
        tag_we = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (!rst) begin
      stall  = 1'b0;
      tag_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_line       <= '0;
      r_we         <= 1'b0;
      r_wb_start   <= 1'b0;
      r_rf_start   <= 1'b0;
      r_wb_addr    <= '0;
      r_rf_addr    <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state    <= w_next;
      r_wb_start <= 1'b0;
      r_rf_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_line <= req_addr[31:5];
            r_we   <= req_we;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_hit_count <= r_hit_count + 32'd1;
          end else begin
            r_miss_count <= r_miss_count + 32'd1;
            // The victim tag is captured directly into the write-back address.
            if (w_victim_dirty) begin
              r_wb_start <= 1'b1;
              r_wb_addr  <= {tag_rd_tag, w_index, 5'b0};
            end else begin
              r_rf_start <= 1'b1;
              r_rf_addr  <= {r_line, 5'b0};
            end
          end
        end
        S_WB_WAIT: begin
          if (wb_done) begin
            r_rf_start <= 1'b1;
            r_rf_addr  <= {r_line, 5'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_start   = r_wb_start;
  assign rf_start   = r_rf_start;
  assign wb_addr    = r_wb_addr;
  assign rf_addr    = r_rf_addr;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: tag-array and transfer-unit models, event scoreboard,
// directed miss/hit scenarios, reset abort and a random back-to-back run.
module tb_cache_miss_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LK   = 3'd1;
  localparam logic [2:0] ST_WB   = 3'd2;
  localparam logic [1:0] EV_WB   = 2'd1;
  localparam logic [1:0] EV_RF   = 2'd2;
  localparam logic [1:0] EV_TW   = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic        stall;
  logic [5:0]  tag_index;
  logic [20:0] tag_rd_tag = '0;
  logic        tag_rd_valid = 1'b0;
  logic        tag_rd_dirty = 1'b0;
  logic        tag_we;
  logic [20:0] tag_wr_tag;
  logic        tag_wr_valid;
  logic        tag_wr_dirty;
  logic        wb_start;
  logic [31:0] wb_addr;
  logic        wb_done = 1'b0;
  logic        rf_start;
  logic [31:0] rf_addr;
  logic        rf_done = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [2:0]  dbg_state;

  cache_miss_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .stall(stall), .tag_index(tag_index), .tag_rd_tag(tag_rd_tag),
    .tag_rd_valid(tag_rd_valid), .tag_rd_dirty(tag_rd_dirty), .tag_we(tag_we),
    .tag_wr_tag(tag_wr_tag), .tag_wr_valid(tag_wr_valid), .tag_wr_dirty(tag_wr_dirty),
    .wb_start(wb_start), .wb_addr(wb_addr), .wb_done(wb_done),
    .rf_start(rf_start), .rf_addr(rf_addr), .rf_done(rf_done),
    .hit_count(hit_count), .miss_count(miss_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tag array written by the DUT, and the bench's own shadow of what it should hold.
  logic [20:0] m_tag [64];
  logic        m_v   [64];
  logic        m_d   [64];
  logic [20:0] s_tag [64];
  logic        s_v   [64];
  logic        s_d   [64];

  always @(posedge clk) begin
    tag_rd_tag   <= m_tag[tag_index];
    tag_rd_valid <= m_v[tag_index];
    tag_rd_dirty <= m_d[tag_index];
    if (tag_we) begin
      m_tag[tag_index] <= tag_wr_tag;
      m_v[tag_index]   <= tag_wr_valid;
      m_d[tag_index]   <= tag_wr_dirty;
    end
  end

  // Transfer-unit responders: done arrives *_lat cycles after the start pulse.
  int wb_lat = 4;
  int rf_lat = 10;
  int wb_pend = 0;
  int rf_pend = 0;
  bit resp_en = 1'b1;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      wb_pend = 0;
      rf_pend = 0;
    end
    if (resp_en) begin
      wb_done = 1'b0;
      rf_done = 1'b0;
      if (wb_pend > 0) begin
        wb_pend--;
        if (wb_pend == 0) wb_done = 1'b1;
      end
      if (rf_pend > 0) begin
        rf_pend--;
        if (rf_pend == 0) rf_done = 1'b1;
      end
      if (rst && wb_start) wb_pend = wb_lat;
      if (rst && rf_start) rf_pend = rf_lat;
    end
  end

  // Scoreboard of DUT-issued events: transfer starts and tag writes.
  logic [33:0] exp_q[$];
  logic [2:0]  exp_rf_prev = ST_LK;
  logic [2:0]  prev_state = ST_IDLE;
  int          cyc = 0;
  int          last_wbd = 0;

  function automatic logic [33:0] ev_tw(input logic [20:0] t, input logic [5:0] i,
                                        input logic d);
    return {EV_TW, t, i, 1'b1, d, 3'b0};
  endfunction

  task automatic observe(input logic [33:0] ev);
    if (exp_q.size() == 0) check("unexpected_event", ev, 34'h0);
    else check("event", ev, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (wb_start) observe({EV_WB, wb_addr});
      if (rf_start) begin
        observe({EV_RF, rf_addr});
        check("rf_prev_state", prev_state, exp_rf_prev);
        if (exp_rf_prev == ST_WB) check("rf_after_wb_done", cyc - last_wbd, 1);
      end
      if (tag_we) observe({EV_TW, tag_wr_tag, tag_index, tag_wr_valid, tag_wr_dirty, 3'b0});
      if (wb_done && dbg_state == ST_WB) last_wbd = cyc;
    end
    prev_state = dbg_state;
  end

  int exp_hits = 0;
  int exp_miss = 0;

  task automatic preload(input logic [5:0] i, input logic [20:0] t, input logic v,
                         input logic d);
    m_tag[i] = t; m_v[i] = v; m_d[i] = d;
    s_tag[i] = t; s_v[i] = v; s_d[i] = d;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_hits = 0;
    exp_miss = 0;
  endtask

  // Entered at posedge+1; returns at posedge+1 just after the hitting LOOKUP.
  task automatic do_access(input logic [31:0] a, input logic w);
    logic [20:0] t;
    logic [5:0]  i;
    int          exp_stall;
    int          n;
    t = a[31:11];
    i = a[10:5];
    if (s_v[i] && s_tag[i] == t) begin
      exp_hits++;
      exp_stall = 1;
      if (w && !s_d[i]) begin
        exp_q.push_back(ev_tw(t, i, 1'b1));
        s_d[i] = 1'b1;
      end
    end else begin
      exp_miss++;
      exp_hits++;
      exp_stall = 4 + rf_lat + 1;
      if (s_v[i] && s_d[i]) begin
        exp_q.push_back({EV_WB, s_tag[i], i, 5'b0});
        exp_stall += wb_lat + 1;
        exp_rf_prev = ST_WB;
      end else begin
        exp_rf_prev = ST_LK;
      end
      exp_q.push_back({EV_RF, t, i, 5'b0});
      exp_q.push_back(ev_tw(t, i, 1'b0));
      if (w) exp_q.push_back(ev_tw(t, i, 1'b1));
      s_tag[i] = t; s_v[i] = 1'b1; s_d[i] = w;
    end
    req = 1'b1;
    req_we = w;
    req_addr = a;
    n = 0;
    @(negedge clk);
    while (stall && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", n, exp_stall);
    check("lookup_no_stall", dbg_state, ST_LK);
    @(posedge clk);
    #1;
  endtask

  task automatic end_test(input logic [5:0] i);
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_miss);
    check("tag_entry", {m_tag[i], m_v[i], m_d[i]}, {s_tag[i], s_v[i], s_d[i]});
  endtask

  initial begin
    for (int k = 0; k < 64; k++) preload(k[5:0], '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_tag_we", tag_we, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_starts", {wb_start, rf_start}, 0);
    check("rst_addrs", {wb_addr, rf_addr}, 0);
    check("rst_counts", {hit_count, miss_count}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Read hit on a clean line.
    preload(6'd3, 21'h1, 1'b1, 1'b0);
    do_access(32'h0000_0860, 1'b0);
    end_test(6'd3);

    // Store hit on a clean line sets dirty.
    do_reset();
    preload(6'd3, 21'h1, 1'b1, 1'b0);
    do_access(32'h0000_0860, 1'b1);
    end_test(6'd3);

    // Clean miss with a 10-cycle refill.
    do_reset();
    preload(6'd3, 21'h1, 1'b1, 1'b0);
    wb_lat = 4; rf_lat = 10;
    do_access(32'h0000_1060, 1'b0);
    end_test(6'd3);
    check("clean_miss_entry", {m_tag[3], m_v[3], m_d[3]}, {21'h2, 1'b1, 1'b0});

    // Dirty victim, store miss.
    do_reset();
    preload(6'd3, 21'h1, 1'b1, 1'b1);
    do_access(32'h0000_1064, 1'b1);
    end_test(6'd3);
    check("dirty_miss_entry", {m_tag[3], m_v[3], m_d[3]}, {21'h2, 1'b1, 1'b1});

    // Invalid line with stale dirty bit: refill only.
    do_reset();
    preload(6'd3, 21'h1, 1'b0, 1'b1);
    do_access(32'h0000_0860, 1'b0);
    end_test(6'd3);

    // Reset during WB_WAIT, then spurious done pulses.
    do_reset();
    preload(6'd3, 21'h1, 1'b1, 1'b1);
    wb_lat = 50;
    exp_q.push_back({EV_WB, 32'h0000_0860});
    req = 1'b1; req_we = 1'b1; req_addr = 32'h0000_1064;
    for (int k = 0; k < 20 && dbg_state != ST_WB; k++) @(negedge clk);
    check("reach_wb_wait", dbg_state, ST_WB);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    check("in_rst_stall_we", {stall, tag_we}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    resp_en = 1'b0;
    @(negedge clk);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_counts", {hit_count, miss_count}, 0);
    check("abort_stall", stall, 0);
    @(posedge clk); #1; wb_done = 1'b1;
    @(posedge clk); #1; wb_done = 1'b0; rf_done = 1'b1;
    @(posedge clk); #1; rf_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("spurious_state", dbg_state, ST_IDLE);
    check("spurious_queue", exp_q.size(), 0);
    resp_en = 1'b1;
    s_v[3] = m_v[3]; s_d[3] = m_d[3]; s_tag[3] = m_tag[3];

    // Random back-to-back accesses over a few conflicting lines.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a;
      a = {19'h0, 2'($urandom_range(1, 3)), ($urandom_range(0, 1) == 1) ? 6'd5 : 6'd3,
           3'($urandom_range(0, 7)), 2'b00};
      wb_lat = $urandom_range(1, 6);
      rf_lat = $urandom_range(1, 6);
      do_access(a, 1'($urandom_range(0, 1)));
    end
    end_test(6'd3);
    check("rand_entry5", {m_tag[5], m_v[5], m_d[5]}, {s_tag[5], s_v[5], s_d[5]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
